prll_bs_drvr_fifo: RTL and testbench

Per-driver transmit FIFO that sits directly upstream of the parallel-bus generator/arbiter. The producer (PS-side logic or a test driver) pushes bus words in; the FIFO presents the head word to the arbiter through the `pndng` / `pop` / `D_pop` handshake. One instance is placed per driver port, for example driver 0 and driver 1 on bus 0. It provides first-word-fall-through output, occupancy reporting and sticky overflow detection.

---
 rtl/prll_bs_drvr_fifo.sv | 110 +++++++++++
 tb/tb_prll_bs_drvr_fifo.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/prll_bs_drvr_fifo.sv
// prll_bs_drvr_fifo: per-driver transmit FIFO feeding the parallel-bus arbiter.
// First-word-fall-through head (D_pop/pndng/pop), occupancy count, sticky
// overflow flag. Optional dropped-push counter behind PRLL_FIFO_DROP_CNT_EN;
// without the macro drop_cnt is tied to zero.
module prll_bs_drvr_fifo #(
  parameter int bits  = 32,
  parameter int depth = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [bits-1:0]          D_push,
  output logic                     full,
  output logic                     pndng,
  input  logic                     pop,
  output logic [bits-1:0]          D_pop,
  output logic [$clog2(depth):0]   count,
  output logic                     ovf,
  input  logic                     clr_ovf,
  output logic [15:0]              drop_cnt
);

  localparam int AW = $clog2(depth);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(depth);

  logic [bits-1:0] mem_q [depth];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q,  count_d;
  logic            ovf_q,    ovf_d;
  logic            wr_en, pop_en, drop;

  // Flags come only from registered count, so no push/pop -> flag paths.
  assign full   = (count_q == DEPTH_C);
  assign pndng  = (count_q != '0);
  assign count  = count_q;
  assign ovf    = ovf_q;
  assign D_pop  = mem_q[rd_ptr_q];

  // A pop while full frees a slot in the same cycle, so the push still lands.
  assign pop_en = pop & pndng;
  assign wr_en  = push & (~full | pop_en);
  assign drop   = push & full & ~pop_en;

  // Next-state for pointers, occupancy and the sticky overflow flag.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (wr_en)  wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_en) rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({wr_en, pop_en})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    // A drop in the same cycle as a clear keeps the flag set.
    if (drop)         ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
  end

  // Control state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage array; cleared on reset so D_pop is never X.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < depth; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_ptr_q] <= D_push;
    end
  end

`ifdef PRLL_FIFO_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // Saturating dropped-push counter; a clear that coincides with a drop loads 1.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (clr_ovf)                           drop_cnt_d = drop ? 16'h0001 : 16'h0000;
    else if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'h0001;
  end

  // Drop counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) drop_cnt_q <= 16'h0000;
    else       drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_prll_bs_drvr_fifo.sv
// Directed self-checking bench for prll_bs_drvr_fifo (bits=32, depth=16).
module tb_prll_bs_drvr_fifo;

  localparam int BITS  = 32;
  localparam int DEPTH = 16;
`ifdef PRLL_FIFO_DROP_CNT_EN
  localparam int DCEN = 1;
`else
  localparam int DCEN = 0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            push;
  logic [BITS-1:0] D_push;
  logic            full;
  logic            pndng;
  logic            pop;
  logic [BITS-1:0] D_pop;
  logic [4:0]      count;
  logic            ovf;
  logic            clr_ovf;
  logic [15:0]     drop_cnt;

  int checks   = 0;
  int failures = 0;

  prll_bs_drvr_fifo #(.bits(BITS), .depth(DEPTH)) dut (
    .clk(clk), .reset(reset), .push(push), .D_push(D_push), .full(full),
    .pndng(pndng), .pop(pop), .D_pop(D_pop), .count(count), .ovf(ovf),
    .clr_ovf(clr_ovf), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; push = 1'b0; pop = 1'b0; clr_ovf = 1'b0; D_push = '0;
    #12;
    checks++; if (pndng !== 1'b0)   begin failures++; $display("FAIL rst_pndng got=%b exp=0", pndng); end
    checks++; if (full !== 1'b0)    begin failures++; $display("FAIL rst_full got=%b exp=0", full); end
    checks++; if (count !== 5'd0)   begin failures++; $display("FAIL rst_count got=%0d exp=0", count); end
    checks++; if (ovf !== 1'b0)     begin failures++; $display("FAIL rst_ovf got=%b exp=0", ovf); end
    checks++; if (drop_cnt !== 16'd0) begin failures++; $display("FAIL rst_drop got=%0d exp=0", drop_cnt); end
    checks++; if (D_pop !== 32'd0)  begin failures++; $display("FAIL rst_dpop got=%h exp=0", D_pop); end
    reset = 1'b0;
    tick();
    pop = 1'b1; tick(); pop = 1'b0;
    checks++; if (count !== 5'd0)   begin failures++; $display("FAIL empty_pop_count got=%0d exp=0", count); end
    checks++; if (ovf !== 1'b0)     begin failures++; $display("FAIL empty_pop_ovf got=%b exp=0", ovf); end
    checks++; if (pndng !== 1'b0)   begin failures++; $display("FAIL empty_pop_pndng got=%b exp=0", pndng); end
  endtask

  task automatic test_basic();
    logic [31:0] e;
    push = 1'b1; D_push = 32'hA000_0001; tick();
    checks++; if (pndng !== 1'b1)   begin failures++; $display("FAIL basic_pndng got=%b exp=1", pndng); end
    checks++; if (D_pop !== 32'hA000_0001) begin failures++; $display("FAIL basic_head got=%h exp=a0000001", D_pop); end
    D_push = 32'hA000_0002; tick();
    D_push = 32'hA000_0003; tick();
    push = 1'b0;
    checks++; if (count !== 5'd3)   begin failures++; $display("FAIL basic_count got=%0d exp=3", count); end
    pop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      e = 32'hA000_0001 + i;
      checks++; if (D_pop !== e) begin failures++; $display("FAIL basic_pop%0d got=%h exp=%h", i, D_pop, e); end
      tick();
    end
    pop = 1'b0;
    checks++; if (count !== 5'd0)   begin failures++; $display("FAIL basic_end_count got=%0d exp=0", count); end
    checks++; if (pndng !== 1'b0)   begin failures++; $display("FAIL basic_end_pndng got=%b exp=0", pndng); end
  endtask

  task automatic test_overflow();
    logic [15:0] e;
    push = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin D_push = i; tick(); end
    push = 1'b0;
    checks++; if (full !== 1'b1)    begin failures++; $display("FAIL ovf_full got=%b exp=1", full); end
    checks++; if (count !== 5'd16)  begin failures++; $display("FAIL ovf_count got=%0d exp=16", count); end
    checks++; if (ovf !== 1'b0)     begin failures++; $display("FAIL ovf_pre got=%b exp=0", ovf); end
    push = 1'b1; D_push = 32'hDEAD; tick(); push = 1'b0;
    e = (DCEN != 0) ? 16'd1 : 16'd0;
    checks++; if (ovf !== 1'b1)     begin failures++; $display("FAIL ovf_set got=%b exp=1", ovf); end
    checks++; if (count !== 5'd16)  begin failures++; $display("FAIL ovf_count2 got=%0d exp=16", count); end
    checks++; if (drop_cnt !== e)   begin failures++; $display("FAIL ovf_drop1 got=%0d exp=%0d", drop_cnt, e); end
    // Drop coinciding with clear: flag stays set, counter reloads to 1.
    push = 1'b1; clr_ovf = 1'b1; D_push = 32'hBEEF; tick(); push = 1'b0; clr_ovf = 1'b0;
    checks++; if (ovf !== 1'b1)     begin failures++; $display("FAIL ovf_setwins got=%b exp=1", ovf); end
    checks++; if (drop_cnt !== e)   begin failures++; $display("FAIL ovf_clrdrop got=%0d exp=%0d", drop_cnt, e); end
    push = 1'b1; tick(); push = 1'b0;
    e = (DCEN != 0) ? 16'd2 : 16'd0;
    checks++; if (drop_cnt !== e)   begin failures++; $display("FAIL ovf_drop2 got=%0d exp=%0d", drop_cnt, e); end
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    checks++; if (ovf !== 1'b0)     begin failures++; $display("FAIL ovf_clr got=%b exp=0", ovf); end
    checks++; if (drop_cnt !== 16'd0) begin failures++; $display("FAIL ovf_clrcnt got=%0d exp=0", drop_cnt); end
    pop = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if (D_pop !== 32'(i)) begin failures++; $display("FAIL ovf_drain%0d got=%h exp=%h", i, D_pop, 32'(i)); end
      tick();
    end
    pop = 1'b0;
    checks++; if (pndng !== 1'b0)   begin failures++; $display("FAIL ovf_drain_pndng got=%b exp=0", pndng); end
    checks++; if (count !== 5'd0)   begin failures++; $display("FAIL ovf_drain_count got=%0d exp=0", count); end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] e;
    push = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin D_push = 32'h10 + i; tick(); end
    push = 1'b0;
    checks++; if (full !== 1'b1)    begin failures++; $display("FAIL fpp_full got=%b exp=1", full); end
    checks++; if (D_pop !== 32'h10) begin failures++; $display("FAIL fpp_head got=%h exp=10", D_pop); end
    push = 1'b1; pop = 1'b1; D_push = 32'h55; tick(); push = 1'b0; pop = 1'b0;
    checks++; if (count !== 5'd16)  begin failures++; $display("FAIL fpp_count got=%0d exp=16", count); end
    checks++; if (ovf !== 1'b0)     begin failures++; $display("FAIL fpp_ovf got=%b exp=0", ovf); end
    pop = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      e = (i < DEPTH-1) ? 32'h11 + i : 32'h55;
      checks++; if (D_pop !== e) begin failures++; $display("FAIL fpp_drain%0d got=%h exp=%h", i, D_pop, e); end
      tick();
    end
    pop = 1'b0;
    checks++; if (count !== 5'd0)   begin failures++; $display("FAIL fpp_end_count got=%0d exp=0", count); end
  endtask

  task automatic test_empty_push_pop();
    push = 1'b1; pop = 1'b1; D_push = 32'h77; tick(); push = 1'b0; pop = 1'b0;
    checks++; if (count !== 5'd1)   begin failures++; $display("FAIL epp_count got=%0d exp=1", count); end
    checks++; if (D_pop !== 32'h77) begin failures++; $display("FAIL epp_head got=%h exp=77", D_pop); end
    checks++; if (pndng !== 1'b1)   begin failures++; $display("FAIL epp_pndng got=%b exp=1", pndng); end
    pop = 1'b1; tick(); pop = 1'b0;
    checks++; if (count !== 5'd0)   begin failures++; $display("FAIL epp_end_count got=%0d exp=0", count); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    push = 1'b1;
    D_push = 32'hB0; tick();
    D_push = 32'hB1; tick();
    pop = 1'b1;
    for (int i = 0; i < 6; i++) begin
      e = 32'hB0 + i;
      D_push = 32'hB2 + i;
      checks++; if (D_pop !== e) begin failures++; $display("FAIL b2b_head%0d got=%h exp=%h", i, D_pop, e); end
      tick();
      checks++; if (count !== 5'd2) begin failures++; $display("FAIL b2b_count%0d got=%0d exp=2", i, count); end
    end
    push = 1'b0;
    for (int i = 0; i < 2; i++) begin
      e = 32'hB6 + i;
      checks++; if (D_pop !== e) begin failures++; $display("FAIL b2b_tail%0d got=%h exp=%h", i, D_pop, e); end
      tick();
    end
    pop = 1'b0;
    checks++; if (pndng !== 1'b0)   begin failures++; $display("FAIL b2b_end_pndng got=%b exp=0", pndng); end
  endtask

  task automatic test_async_reset();
    push = 1'b1;
    for (int i = 0; i < 5; i++) begin D_push = 32'hC0 + i; tick(); end
    push = 1'b0;
    checks++; if (count !== 5'd5)   begin failures++; $display("FAIL arst_pre_count got=%0d exp=5", count); end
    #3 reset = 1'b1;
    #1;
    checks++; if (count !== 5'd0)   begin failures++; $display("FAIL arst_count got=%0d exp=0", count); end
    checks++; if (pndng !== 1'b0)   begin failures++; $display("FAIL arst_pndng got=%b exp=0", pndng); end
    #1 reset = 1'b0;
    push = 1'b1; D_push = 32'h99; tick(); push = 1'b0;
    checks++; if (D_pop !== 32'h99) begin failures++; $display("FAIL arst_head got=%h exp=99", D_pop); end
    checks++; if (count !== 5'd1)   begin failures++; $display("FAIL arst_post_count got=%0d exp=1", count); end
    pop = 1'b1; tick(); pop = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_full_push_pop();
    test_empty_push_pop();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
